// File: rtl/addr_pkg.sv
// Chip-level address map types shared by every block that decodes or drives the address bus.
// Layout (27 bits): {is_zap, zap_id[5:0], non_zap_block_id[2:0], offset[16:0]}.
package addr_pkg;

    typedef logic [5:0] zap_id_t;

    typedef enum logic {
        IS_ZAP_NON_ZAP = 1'b0,
        IS_ZAP_ZAP     = 1'b1
    } IS_ZAP_E;

    typedef enum logic [2:0] {
        NZ_BLK_SRAM   = 3'd0,
        NZ_BLK_ROM    = 3'd1,
        NZ_BLK_CSR    = 3'd2,
        NZ_BLK_UNUSED = 3'd3,
        NZ_BLK_DMA    = 3'd4,
        NZ_BLK_DBG    = 3'd5,
        NZ_BLK_PLL    = 3'd6,
        NZ_BLK_FUSE   = 3'd7
    } NON_ZAP_BLOCK_ID_E;

    typedef struct packed {
        IS_ZAP_E           is_zap;
        zap_id_t           zap_id;
        NON_ZAP_BLOCK_ID_E non_zap_block_id;
        logic [16:0]       offset;
    } addr_t;

endpackage

// File: rtl/addr_req_arb_pkg.sv
// Shared types, constants and target-decode helpers for the address request arbiter.
package addr_req_arb_pkg;
    import addr_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } addr_req_arb_state_e;

    // Nibble replicated across the read data on a watchdog timeout.
    localparam logic [3:0] ADDR_REQ_ARB_ERR_DATA = 4'hE;

    localparam logic [2:0] ADDR_REQ_ARB_ILLEGAL_BLK = 3'd3;

    function automatic logic [5:0] addr_req_arb_tgt_id(input addr_t a);
        return (a.is_zap == IS_ZAP_ZAP) ? a.zap_id : {3'b000, a.non_zap_block_id};
    endfunction

    function automatic logic addr_req_arb_illegal(input addr_t a);
        return (a.is_zap == IS_ZAP_NON_ZAP) && (a.non_zap_block_id == ADDR_REQ_ARB_ILLEGAL_BLK);
    endfunction

endpackage

// File: rtl/addr_req_arb_if.sv
// Requester-side and downstream-bus signals of the address request arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface addr_req_arb_if
    import addr_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    addr_t                 req_addr  [NUM_REQ];
    logic [NUM_REQ-1:0]    req_wr;
    logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  bus_valid;
    logic                  bus_ready;
    addr_t                 bus_addr;
    logic                  bus_wr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_tgt_zap;
    logic [5:0]            bus_tgt_id;
    logic                  bus_rsp_valid;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_err;

    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata,
        input  bus_ready, bus_rsp_valid, bus_rdata, bus_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_valid, bus_addr, bus_wr, bus_wdata, bus_tgt_zap, bus_tgt_id
    );

    modport master (
        output req_valid, req_addr, req_wr, req_wdata,
        output bus_ready, bus_rsp_valid, bus_rdata, bus_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_valid, bus_addr, bus_wr, bus_wdata, bus_tgt_zap, bus_tgt_id
    );

endinterface

// File: rtl/addr_req_arb_rr_arb.sv
// Combinational round-robin picker: grants the first set request at or after ptr,
// wrapping modulo NUM_REQ, as a one-hot vector plus its index.
module addr_req_arb_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
    localparam int IW = $clog2(NUM_REQ);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((32'(ptr) + 32'(i)) % 32'(NUM_REQ));
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/addr_req_arb.sv
// Round-robin arbiter sharing the chip address bus among NUM_REQ requesters, one transaction at a time.
// Define ADDR_REQ_ARB_WATCHDOG_EN to add a WAIT-state timeout that answers with an error.
module addr_req_arb
    import addr_pkg::*;
    import addr_req_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    addr_req_arb_if.slave io
);
    localparam int IW = $clog2(NUM_REQ);

    addr_req_arb_state_e   state;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         gnt_idx;
    logic [IW-1:0]         next_ptr;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    gnt_q;
    logic                  any_req;

    addr_t                 sel_addr;
    logic                  sel_zap;
    logic                  sel_illegal;
    logic [5:0]            sel_tgt_id;

    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  bus_valid_q;
    addr_t                 bus_addr_q;
    logic                  bus_wr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic                  bus_tgt_zap_q;
    logic [5:0]            bus_tgt_id_q;

`ifdef ADDR_REQ_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;
`endif

    addr_req_arb_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req     (io.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_req     = |io.req_valid;
    assign sel_addr    = io.req_addr[gnt_idx];
    assign sel_zap     = (sel_addr.is_zap == IS_ZAP_ZAP);
    assign sel_illegal = addr_req_arb_illegal(sel_addr);
    assign sel_tgt_id  = addr_req_arb_tgt_id(sel_addr);
    assign next_ptr    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // The grant is the only combinational output: a requester sees it in the cycle it is taken.
    assign io.req_ready   = (state == IDLE && !rst) ? gnt : '0;
    assign io.rsp_valid   = rsp_valid_q;
    assign io.rsp_rdata   = rsp_rdata_q;
    assign io.rsp_err     = rsp_err_q;
    assign io.bus_valid   = bus_valid_q;
    assign io.bus_addr    = bus_addr_q;
    assign io.bus_wr      = bus_wr_q;
    assign io.bus_wdata   = bus_wdata_q;
    assign io.bus_tgt_zap = bus_tgt_zap_q;
    assign io.bus_tgt_id  = bus_tgt_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_q      <= 1'b0;
            bus_wdata_q   <= '0;
            bus_tgt_zap_q <= 1'b0;
            bus_tgt_id_q  <= '0;
`ifdef ADDR_REQ_ARB_WATCHDOG_EN
            wdog_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q         <= gnt;
                        rr_ptr        <= next_ptr;
                        bus_addr_q    <= sel_addr;
                        bus_wr_q      <= io.req_wr[gnt_idx];
                        bus_wdata_q   <= io.req_wdata[gnt_idx];
                        bus_tgt_zap_q <= sel_zap;
                        bus_tgt_id_q  <= sel_tgt_id;
                        // An unused block encoding never reaches the bus; answer locally with an error.
                        if (sel_illegal) begin
                            rsp_valid_q <= gnt;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            state       <= RESP;
                        end else begin
                            bus_valid_q <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus_valid_q && io.bus_ready) begin
                        bus_valid_q <= 1'b0;
                        state       <= WAIT;
`ifdef ADDR_REQ_ARB_WATCHDOG_EN
                        wdog_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (io.bus_rsp_valid) begin
                        rsp_valid_q <= gnt_q;
                        rsp_rdata_q <= io.bus_rdata;
                        rsp_err_q   <= io.bus_err;
                        state       <= RESP;
                    end
`ifdef ADDR_REQ_ARB_WATCHDOG_EN
                    else if (wdog_cnt == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        wdog_cnt    <= wdog_cnt + 1'b1;
                        rsp_valid_q <= gnt_q;
                        rsp_rdata_q <= {(DATA_WIDTH / 4){ADDR_REQ_ARB_ERR_DATA}};
                        rsp_err_q   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wdog_cnt    <= wdog_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_req_arb.sv
// Directed self-checking bench for addr_req_arb with a response scoreboard.
// Define ADDR_REQ_ARB_WATCHDOG_EN to also exercise the timeout path.
module tb_addr_req_arb;
    import addr_pkg::*;
    import addr_req_arb_pkg::*;

    localparam int NUM_REQ        = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        logic [NUM_REQ-1:0]    onehot;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } exp_rsp_t;

    logic     clk = 1'b0;
    logic     rst;
    int       checks = 0;
    int       errors = 0;
    exp_rsp_t exp_q[$];
    exp_rsp_t mon_item;

    addr_req_arb_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) io ();

    addr_req_arb #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    function automatic addr_t mk_zap(input logic [5:0] id);
        addr_t a;
        a        = '0;
        a.is_zap = IS_ZAP_ZAP;
        a.zap_id = id;
        a.offset = 17'h1_0040 ^ {11'd0, id};
        return a;
    endfunction

    function automatic addr_t mk_nz(input logic [2:0] blk);
        addr_t a;
        a                  = '0;
        a.is_zap           = IS_ZAP_NON_ZAP;
        a.non_zap_block_id = NON_ZAP_BLOCK_ID_E'(blk);
        a.offset           = 17'h0_0ABC;
        return a;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input addr_t addr, input logic wr,
                                 input logic [DATA_WIDTH-1:0] wdata);
        io.req_addr[idx]  = addr;
        io.req_wr[idx]    = wr;
        io.req_wdata[idx] = wdata;
        io.req_valid[idx] = 1'b1;
    endtask

    task automatic push_exp(input logic [NUM_REQ-1:0] onehot, input logic [DATA_WIDTH-1:0] rdata,
                            input logic err);
        exp_rsp_t e;
        e.onehot = onehot;
        e.rdata  = rdata;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // Entered at the negedge of the grant cycle; returns at the negedge of the following IDLE cycle.
    task automatic serve_zero_wait(input string tag, input int drop_idx, input addr_t exp_addr,
                                   input logic exp_zap, input logic [5:0] exp_id,
                                   input logic [NUM_REQ-1:0] exp_onehot,
                                   input logic [DATA_WIDTH-1:0] rdata, input logic err);
        io.bus_ready = 1'b1;
        @(negedge clk);
        if (drop_idx >= 0) io.req_valid[drop_idx] = 1'b0;
        checkOutput({tag, "_bus_valid"}, io.bus_valid, 1);
        checkOutput({tag, "_bus_addr"}, io.bus_addr, exp_addr);
        checkOutput({tag, "_tgt_zap"}, io.bus_tgt_zap, exp_zap);
        checkOutput({tag, "_tgt_id"}, io.bus_tgt_id, exp_id);
        @(negedge clk);
        io.bus_ready = 1'b0;
        checkOutput({tag, "_bus_valid_wait"}, io.bus_valid, 0);
        io.bus_rsp_valid = 1'b1;
        io.bus_rdata     = rdata;
        io.bus_err       = err;
        @(negedge clk);
        io.bus_rsp_valid = 1'b0;
        io.bus_err       = 1'b0;
        checkOutput({tag, "_rsp_valid"}, io.rsp_valid, exp_onehot);
        @(negedge clk);
    endtask

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (io.rsp_valid != '0)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", io.rsp_valid, 0);
            end else begin
                mon_item = exp_q.pop_front();
                checkOutput("sb_rsp_valid", io.rsp_valid, mon_item.onehot);
                checkOutput("sb_rsp_rdata", io.rsp_rdata, mon_item.rdata);
                checkOutput("sb_rsp_err", io.rsp_err, mon_item.err);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: bench did not reach its end");
        $fatal(1, "[TB] bench stuck");
    end

    initial begin
        rst              = 1'b1;
        io.req_valid     = '0;
        io.req_wr        = '0;
        io.bus_ready     = 1'b0;
        io.bus_rsp_valid = 1'b0;
        io.bus_rdata     = '0;
        io.bus_err       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            io.req_addr[i]  = '0;
            io.req_wdata[i] = '0;
        end

        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", io.req_ready, 0);
        checkOutput("rst_rsp_valid", io.rsp_valid, 0);
        checkOutput("rst_bus_valid", io.bus_valid, 0);
        checkOutput("rst_bus_fields", {io.bus_addr, io.bus_wr, io.bus_tgt_zap, io.bus_tgt_id}, 0);
        checkOutput("rst_bus_wdata", io.bus_wdata, 0);
        checkOutput("rst_rsp_data", {io.rsp_rdata, io.rsp_err}, 0);
        rst = 1'b0;

        $display("[TB] rotation with all requesters active");
        for (int i = 0; i < NUM_REQ; i++)
            applyStimulus(i, mk_zap(6'(i + 1)), 1'b0, 32'h1111_1111 * i);
        for (int g = 0; g < 12; g++) begin
            #1;
            checkOutput("rot_grant", io.req_ready, 4'b0001 << (g % 4));
            checkOutput("rot_onehot", $onehot(io.req_ready), 1);
            push_exp(4'b0001 << (g % 4), 32'hA000_0000 + g, 1'b0);
            serve_zero_wait("rot", -1, mk_zap(6'((g % 4) + 1)), 1'b1, 6'((g % 4) + 1),
                            4'b0001 << (g % 4), 32'hA000_0000 + g, 1'b0);
        end
        io.req_valid = '0;
        @(negedge clk);

        $display("[TB] single zap read from requester 0");
        applyStimulus(0, mk_zap(6'h0A), 1'b0, 32'h0);
        #1;
        checkOutput("rd_grant", io.req_ready, 4'b0001);
        push_exp(4'b0001, 32'h1234_5678, 1'b0);
        serve_zero_wait("rd", 0, mk_zap(6'h0A), 1'b1, 6'h0A, 4'b0001, 32'h1234_5678, 1'b0);

        $display("[TB] illegal non-zap block");
        applyStimulus(1, mk_nz(3'd3), 1'b0, 32'h0);
        #1;
        checkOutput("ill_grant", io.req_ready, 4'b0010);
        push_exp(4'b0010, 32'h0, 1'b1);
        @(negedge clk);
        io.req_valid[1] = 1'b0;
        checkOutput("ill_bus_valid", io.bus_valid, 0);
        checkOutput("ill_rsp_valid", io.rsp_valid, 4'b0010);
        checkOutput("ill_tgt", {io.bus_tgt_zap, io.bus_tgt_id}, 7'h03);
        @(negedge clk);
        checkOutput("ill_bus_valid_after", io.bus_valid, 0);
        checkOutput("ill_rsp_done", io.rsp_valid, 0);

        $display("[TB] stalled bus_ready with early stray response");
        applyStimulus(2, mk_nz(3'd5), 1'b1, 32'hCAFE_F00D);
        io.bus_ready = 1'b0;
        #1;
        checkOutput("stall_grant", io.req_ready, 4'b0100);
        push_exp(4'b0100, 32'h0BAD_BEEF, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) io.req_valid[2] = 1'b0;
            io.bus_rsp_valid = (k == 3);
            io.bus_rdata     = 32'hDEAD_0000;
            checkOutput("stall_bus_valid", io.bus_valid, 1);
            checkOutput("stall_bus_addr", io.bus_addr, mk_nz(3'd5));
            checkOutput("stall_bus_wdata", io.bus_wdata, 32'hCAFE_F00D);
            checkOutput("stall_bus_wr_tgt", {io.bus_wr, io.bus_tgt_zap, io.bus_tgt_id}, {1'b1, 1'b0, 6'h05});
            checkOutput("stall_rsp_valid", io.rsp_valid, 0);
            if (k == 6) io.bus_ready = 1'b1;
        end
        @(negedge clk);
        io.bus_ready = 1'b0;
        checkOutput("stall_wait_bus_valid", io.bus_valid, 0);
        checkOutput("stall_wait_rsp_valid", io.rsp_valid, 0);
        io.bus_rsp_valid = 1'b1;
        io.bus_rdata     = 32'h0BAD_BEEF;
        io.bus_err       = 1'b1;
        @(negedge clk);
        io.bus_rsp_valid = 1'b0;
        io.bus_err       = 1'b0;
        checkOutput("stall_rsp", io.rsp_valid, 4'b0100);
        @(negedge clk);

`ifdef ADDR_REQ_ARB_WATCHDOG_EN
        $display("[TB] watchdog timeout");
        applyStimulus(3, mk_zap(6'h15), 1'b0, 32'h0);
        io.bus_ready = 1'b1;
        #1;
        checkOutput("wd_grant", io.req_ready, 4'b1000);
        push_exp(4'b1000, 32'hEEEE_EEEE, 1'b1);
        @(negedge clk);
        io.req_valid[3] = 1'b0;
        checkOutput("wd_bus_valid", io.bus_valid, 1);
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            io.bus_ready = 1'b0;
            checkOutput("wd_waiting", io.rsp_valid, 0);
        end
        @(negedge clk);
        checkOutput("wd_rsp_valid", io.rsp_valid, 4'b1000);
        @(negedge clk);
        io.bus_rsp_valid = 1'b1;
        io.bus_rdata     = 32'h7777_7777;
        @(negedge clk);
        io.bus_rsp_valid = 1'b0;
        checkOutput("wd_late_dropped", io.rsp_valid, 0);
        applyStimulus(0, mk_zap(6'h01), 1'b0, 32'h0);
        #1;
        checkOutput("wd_next_grant", io.req_ready, 4'b0001);
        push_exp(4'b0001, 32'h5555_AAAA, 1'b0);
        serve_zero_wait("wd_next", 0, mk_zap(6'h01), 1'b1, 6'h01, 4'b0001, 32'h5555_AAAA, 1'b0);
`endif

        $display("[TB] reset while waiting for a response");
        applyStimulus(2, mk_zap(6'h22), 1'b1, 32'h89AB_CDEF);
        io.bus_ready = 1'b1;
        #1;
        checkOutput("ar_grant", io.req_ready, 4'b0100);
        push_exp(4'b0100, 32'h0, 1'b0);
        @(negedge clk);
        io.req_valid[2] = 1'b0;
        checkOutput("ar_bus_valid", io.bus_valid, 1);
        @(negedge clk);
        io.bus_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_bus_fields", {io.bus_valid, io.bus_addr, io.bus_wr, io.bus_tgt_zap, io.bus_tgt_id}, 0);
        checkOutput("ar_bus_wdata", io.bus_wdata, 0);
        checkOutput("ar_rsp", {io.rsp_valid, io.rsp_rdata, io.rsp_err}, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ar_no_rsp", io.rsp_valid, 0);
        applyStimulus(2, mk_zap(6'h23), 1'b0, 32'h0);
        applyStimulus(3, mk_zap(6'h24), 1'b0, 32'h0);
        #1;
        checkOutput("ar_ptr_grant", io.req_ready, 4'b0100);
        push_exp(4'b0100, 32'h2222_0002, 1'b0);
        serve_zero_wait("ar_r2", 2, mk_zap(6'h23), 1'b1, 6'h23, 4'b0100, 32'h2222_0002, 1'b0);
        #1;
        checkOutput("ar_next_grant", io.req_ready, 4'b1000);
        push_exp(4'b1000, 32'h3333_0003, 1'b0);
        serve_zero_wait("ar_r3", 3, mk_zap(6'h24), 1'b1, 6'h24, 4'b1000, 32'h3333_0003, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_req_arb.md
# addr_req_arb

Round-robin arbiter that shares the single chip-level address bus (`addr_t`, 27 bits) among `NUM_REQ` requesters such as host bridge, debug port and DMA. It accepts one request at a time and decodes the target from the address fields (zap vs non-zap, zap_id, non_zap_block_id). It drives the shared bus, waits for the single outstanding response, and routes the response back to the winning requester. An optional watchdog returns an error response if the target never answers.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 32: read/write data width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in WAIT. Used only with the watchdog compiled in.

Ports:
- `clk`  in  1: the block's one clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_ready`  out  NUM_REQ: one-hot grant, high for one cycle in IDLE.
- `req_addr`  in  NUM_REQ x `addr_t`: request address.
- `req_wr`  in  NUM_REQ: 1 = write, 0 = read.
- `req_wdata`  in  NUM_REQ x DATA_WIDTH: write data.
- `rsp_valid`  out  NUM_REQ: one-hot response strobe to the granted requester.
- `rsp_rdata`  out  DATA_WIDTH: shared read data, meaningful only with `rsp_valid`.
- `rsp_err`  out  1: shared error flag, meaningful only with `rsp_valid`.
- `bus_valid`  out  1: downstream request valid.
- `bus_ready`  in  1: downstream accept.
- `bus_addr`  out  `addr_t`: registered copy of the granted address.
- `bus_wr`  out  1: registered copy of the granted `req_wr`.
- `bus_wdata`  out  DATA_WIDTH: registered copy of the granted `req_wdata`.
- `bus_tgt_zap`  out  1: 1 when `is_zap == IS_ZAP_ZAP`.
- `bus_tgt_id`  out  6: `zap_id_t` when the target is a zap, else {3'b0, `non_zap_block_id`}.
- `bus_rsp_valid`  in  1: downstream response valid.
- `bus_rdata`  in  DATA_WIDTH: downstream read data.
- `bus_err`  in  1: downstream error.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready[g]` in the same cycle.
  - Capture addr, wr and wdata into registers; compute `bus_tgt_*`.
  - Set `rr_ptr` to (g+1) mod NUM_REQ.
  - Go to ISSUE, or to RESP with error if the decode is illegal.
- Illegal decode: `is_zap == IS_ZAP_NON_ZAP` with `non_zap_block_id == 3'd3` (unused encoding).
  - No bus cycle is issued.
  - RESP is entered with `rsp_err` = 1 and `rsp_rdata` = 0.
- ISSUE:
  - `bus_valid` is held high and all `bus_*` outputs are held stable until `bus_ready`.
  - On `bus_valid & bus_ready`, go to WAIT.
- WAIT:
  - On `bus_rsp_valid`, capture `bus_rdata` and `bus_err`, then go to RESP.
  - `bus_rsp_valid` in any state other than WAIT is ignored and dropped.
- RESP:
  - `rsp_valid[g]` is high for exactly one cycle with the captured data and error.
  - Then go to IDLE.
- Requesters must hold `req_valid` and their payload until `req_ready`. Dropping `req_valid` before grant is legal; that requester is simply not considered.
- A requester must not issue a new request before its `rsp_valid`.

## Timing
- Reset values:
  - State = IDLE, `rr_ptr` = 0.
  - All `req_ready`, `rsp_valid`, `bus_valid` = 0.
  - `rsp_rdata`, `rsp_err`, `bus_addr`, `bus_wr`, `bus_wdata`, `bus_tgt_zap`, `bus_tgt_id` = 0.
  - Watchdog counter = 0.
- Latency with zero-wait downstream:
  - Grant in cycle 0.
  - `bus_valid` in cycle 1, with `bus_ready` in cycle 1.
  - `bus_rsp_valid` no earlier than cycle 2.
  - `rsp_valid` the cycle after `bus_rsp_valid`.
- Minimum request-to-request spacing is 4 cycles.
- Reset asserted mid-transaction returns everything to IDLE immediately. No response is produced for the aborted request.
- Simultaneous requests from all requesters: each is served once per NUM_REQ grants, in rotation.

## Configuration
- Macro `ADDR_REQ_ARB_WATCHDOG_EN`.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES with no `bus_rsp_valid`, go to RESP with `rsp_err` = 1 and `rsp_rdata` = {DATA_WIDTH/4{4'hE}}.
  - A response arriving in the same cycle as expiry wins over the timeout.
- Undefined: no counter is present, and WAIT waits indefinitely.

## Structure
- The shared package holds:
  - `addr_req_arb_state_e` (2-bit enum: IDLE, ISSUE, WAIT, RESP).
  - `ADDR_REQ_ARB_ERR_DATA`.
  - The illegal `non_zap_block_id` constant, 3'd3.
- `addr_t`, `zap_id_t`, `IS_ZAP_E` and `NON_ZAP_BLOCK_ID_E` are reused from the existing address package.
- One sub-module, `rr_arb`: a parameterised round-robin one-hot picker taking `req` and `ptr` and producing `gnt` and `gnt_idx`. It is purely combinational.

## Test plan
- Single read from req 0 to a zap address, zap_id=6'h0A, zero-wait bus, `bus_rdata`=32'h1234_5678:
  - `bus_tgt_zap`=1 and `bus_tgt_id`=6'h0A in cycle 1.
  - `rsp_valid`=4'b0001 with rdata 32'h1234_5678 and err 0 in cycle 3.
- All 4 requesters hold `req_valid` for 12 grants:
  - Grant order is 0,1,2,3 repeated three times.
  - `req_ready` is always one-hot.
- Non-zap address with `non_zap_block_id`=3'd3:
  - `bus_valid` is never asserted.
  - `rsp_valid` arrives 1 cycle after grant with err=1 and rdata=0.
- `bus_ready` held low for 5 cycles:
  - `bus_valid`, `bus_addr` and `bus_wdata` stay stable for all 6 cycles.
  - WAIT is entered only after the handshake.
- With watchdog, TIMEOUT_CYCLES=16, no response:
  - `rsp_err`=1 and rdata=32'hEEEE_EEEE after 16 WAIT cycles.
  - A late `bus_rsp_valid` is dropped, and a following request completes normally.
- `rst` pulsed while in WAIT:
  - All outputs return to their reset values asynchronously.
  - No `rsp_valid` is produced.
  - The next request from req 2 is granted with `rr_ptr` back at 0.
